// File: rtl/size_handler_mux_pipe_pkg.sv
// Shared encodings and the lane extension helpers for size_handler_mux_pipe.
// Sign extension is only requested by callers built with SIZEHANDLER_SIGNEXT_EN.
package sizehandler_pkg;

    typedef enum logic [1:0] {
        SZ_FULL = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } buf_state_e;

    // Fill bit used for everything above the low 16 result bits.
    function automatic logic ext_fill(input logic [15:0] lane, input logic is_half,
                                      input logic sign_en);
        return sign_en & (is_half ? lane[15] : lane[7]);
    endfunction

    function automatic logic [15:0] ext_lane16(input logic [15:0] lane, input logic is_half,
                                               input logic sign_en);
        logic fill;
        fill = ext_fill(lane, is_half, sign_en);
        return is_half ? lane : {{8{fill}}, lane[7:0]};
    endfunction

endpackage

// File: rtl/size_handler_mux_pipe_size_extract.sv
// Combinational channel select plus FULL/HALF/BYTE lane extraction and extension.
// SIZEHANDLER_SIGNEXT_EN enables sign extension controlled by is_unsigned.
module size_extract
    import sizehandler_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N_IN  = 4,
    localparam int SEL_W = $clog2(N_IN),
    localparam int OFF_W = $clog2(WIDTH / 8)
) (
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [1:0]            size,
    input  logic [OFF_W-1:0]      offset,
    input  logic                  is_unsigned,
    output logic                  err,
    output logic [WIDTH-1:0]      data
);

    logic [WIDTH-1:0] word;
    logic [15:0]      lane;
    logic             sel_bad;
    logic             half_bad;
    logic             is_half;
    logic             do_sign;

`ifdef SIZEHANDLER_SIGNEXT_EN
    assign do_sign = ~is_unsigned;
`else
    logic unused_is_unsigned;
    assign unused_is_unsigned = is_unsigned;
    assign do_sign            = 1'b0;
`endif

    always_comb begin
        word = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (32'(sel) == 32'(k)) begin
                word = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Lanes that start past the top of the word shift in zeros.
    assign lane     = 16'(word >> {offset, 3'b000});
    assign sel_bad  = 32'(sel) >= 32'(N_IN);
    assign half_bad = offset[0] | ((32'(offset) * 32'd8 + 32'd16) > 32'(WIDTH));
    assign is_half  = (size == SZ_HALF);

    always_comb begin
        err  = 1'b0;
        data = '0;
        if (sel_bad || size == SZ_RSVD || (is_half && half_bad)) begin
            err = 1'b1;
        end else if (size == SZ_FULL) begin
            data = word;
        end else begin
            data = {{(WIDTH-16){ext_fill(lane, is_half, do_sign)}},
                    ext_lane16(lane, is_half, do_sign)};
        end
    end

endmodule

// File: rtl/size_handler_mux_pipe.sv
// N:1 select with load-size extraction feeding a 2-entry FIFO behind valid/ready.
// Build option SIZEHANDLER_SIGNEXT_EN selects sign extension for HALF/BYTE lanes.
module size_handler_mux_pipe
    import sizehandler_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N_IN  = 4,
    localparam int SEL_W = $clog2(N_IN),
    localparam int OFF_W = $clog2(WIDTH / 8)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [1:0]            size,
    input  logic [OFF_W-1:0]      offset,
    input  logic                  is_unsigned,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_err,
    output logic [1:0]            dbg_state
);

    // Handshake: a transfer happens at a rising edge where valid & ready are both 1;
    // ready never depends on valid, and a held output stays stable until it transfers.

    buf_state_e     state_q, state_d;
    logic [WIDTH:0] head_q, head_d;
    logic [WIDTH:0] tail_q, tail_d;
    logic           rdy_q, rdy_d;

    logic             x_err;
    logic [WIDTH-1:0] x_data;
    logic             push;
    logic             pop;

    size_extract #(
        .WIDTH (WIDTH),
        .N_IN  (N_IN)
    ) u_extract (
        .sel         (sel),
        .in_data     (in_data),
        .size        (size),
        .offset      (offset),
        .is_unsigned (is_unsigned),
        .err         (x_err),
        .data        (x_data)
    );

    assign in_ready  = rdy_q & (state_q != ST_TWO);
    assign out_valid = (state_q != ST_EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_data  = head_q[WIDTH-1:0];
    assign out_err   = head_q[WIDTH];
    assign dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        rdy_d   = 1'b1;
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    head_d  = {x_err, x_data};
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    head_d = {x_err, x_data};
                end else if (push) begin
                    tail_d  = {x_err, x_data};
                    state_d = ST_TWO;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            rdy_q   <= rdy_d;
        end
    end

endmodule

// File: tb/tb_size_handler_mux_pipe.sv
// Directed bench for size_handler_mux_pipe (WIDTH=32, N_IN=3) with a queue-based reference model.
module tb_size_handler_mux_pipe;
    import sizehandler_pkg::*;

    localparam int W = 32;
    localparam int N = 3;

    logic          clk;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    sel;
    logic [N*W-1:0] in_data;
    logic [1:0]    size;
    logic [1:0]    offset;
    logic          is_unsigned;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_err;
    logic [1:0]    dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W:0]   exp_q[$];
    logic [W-1:0] got_q[$];
    logic         seen_edge;

    size_handler_mux_pipe #(.WIDTH(W), .N_IN(N)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .sel         (sel),
        .in_data     (in_data),
        .size        (size),
        .offset      (offset),
        .is_unsigned (is_unsigned),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_err     (out_err),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result computed from the extraction rules with plain integer arithmetic.
    function automatic logic [W:0] model(input logic [N*W-1:0] d, input logic [1:0] s,
                                         input logic [1:0] sz, input logic [1:0] off,
                                         input logic uns);
        int unsigned word, lane, bits, o, si;
        bit          sgn;
        o  = off;
        si = s;
        if (si >= N || sz == 2'b11 || (sz == 2'b01 && (o % 2 == 1 || o * 8 + 16 > W)))
            return {1'b1, 32'h0};
        word = d[si*W +: W];
        if (sz == 2'b00) return {1'b0, word};
        bits = (sz == 2'b01) ? 16 : 8;
        lane = (word >> (o * 8)) % (32'd1 << bits);
`ifdef SIZEHANDLER_SIGNEXT_EN
        sgn = !uns && (lane >= (32'd1 << (bits - 1)));
`else
        sgn = 1'b0;
        if (uns) sgn = 1'b0;
`endif
        if (sgn) lane = lane | ~((32'd1 << bits) - 1);
        return {1'b0, lane};
    endfunction

    // in_ready may rise only after a clock edge seen with reset released
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) seen_edge <= 1'b0;
        else          seen_edge <= 1'b1;
    end

    // ---------------- per-cycle compare process ----------------
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
        end else begin
            check("in_ready", 64'(in_ready), 64'(seen_edge && exp_q.size() < 2));
            check("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
            if (out_valid && exp_q.size() > 0)
                check("head", {31'h0, out_err, out_data}, 64'(exp_q[0]));
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(in_data, sel, size, offset, is_unsigned));
        end
    end

    // ---------------- drivers ----------------
    task automatic set_ch(input int k, input logic [W-1:0] w);
        in_data[k*W +: W] = w;
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that accepted the request.
    task automatic send(input logic [1:0] s, input logic [1:0] sz, input logic [1:0] off,
                        input logic u);
        int n;
        sel = s; size = sz; offset = off; is_unsigned = u; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("send_accept", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    typedef struct {
        logic [W-1:0] word;
        logic [1:0]   s;
        logic [1:0]   sz;
        logic [1:0]   off;
        logic         uns;
        logic         err;
        logic [W-1:0] exp_se;
        logic [W-1:0] exp_ze;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{32'h80FF_0000, 2'd0, 2'b10, 2'd3, 1'b0, 1'b0, 32'hFFFF_FF80, 32'h0000_0080};
        vecs[1] = '{32'h80FF_0000, 2'd0, 2'b10, 2'd3, 1'b1, 1'b0, 32'h0000_0080, 32'h0000_0080};
        vecs[2] = '{32'h80FF_0000, 2'd0, 2'b10, 2'd2, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_00FF};
        vecs[3] = '{32'h80FF_0000, 2'd0, 2'b01, 2'd2, 1'b0, 1'b0, 32'hFFFF_80FF, 32'h0000_80FF};
        vecs[4] = '{32'h1234_8765, 2'd0, 2'b01, 2'd0, 1'b1, 1'b0, 32'h0000_8765, 32'h0000_8765};
        vecs[5] = '{32'h1234_8765, 2'd0, 2'b01, 2'd1, 1'b0, 1'b1, 32'h0,         32'h0};
        vecs[6] = '{32'h1234_8765, 2'd3, 2'b00, 2'd0, 1'b0, 1'b1, 32'h0,         32'h0};
        vecs[7] = '{32'h1234_8765, 2'd0, 2'b11, 2'd0, 1'b0, 1'b1, 32'h0,         32'h0};
        vecs[8] = '{32'h1234_8765, 2'd0, 2'b00, 2'd3, 1'b0, 1'b0, 32'h1234_8765, 32'h1234_8765};
    end

    // ---------------- main sequence ----------------
    initial begin
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        sel = '0; size = '0; offset = '0; is_unsigned = 1'b0; in_data = '0;
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_err", 64'(out_err), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        #1 check("ready_before_edge", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        check("ready_after_edge", 64'(in_ready), 64'd1);

        // full word through channel 2, one edge of latency
        set_ch(0, 32'h0BAD_0000); set_ch(1, 32'h1111_2222); set_ch(2, 32'hDEAD_BEEF);
        send(2'd2, 2'b00, 2'd0, 1'b0);
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_data", 64'(out_data), 64'hDEAD_BEEF);
        check("t1_err", 64'(out_err), 64'd0);

        // extraction table, each result is the head right after its push
        foreach (vecs[i]) begin
            set_ch(0, vecs[i].word);
            send(vecs[i].s, vecs[i].sz, vecs[i].off, vecs[i].uns);
            check($sformatf("vec%0d_err", i), 64'(out_err), 64'(vecs[i].err));
`ifdef SIZEHANDLER_SIGNEXT_EN
            check($sformatf("vec%0d_data", i), 64'(out_data), 64'(vecs[i].exp_se));
`else
            check($sformatf("vec%0d_data", i), 64'(out_data), 64'(vecs[i].exp_ze));
`endif
        end
        idle(2);

        // backpressure: A,B fill the buffer, C waits
        got_q.delete();
        out_ready = 1'b0;
        set_ch(0, 32'hAAAA_0001); send(2'd0, 2'b00, 2'd0, 1'b0);
        set_ch(0, 32'hBBBB_0002); send(2'd0, 2'b00, 2'd0, 1'b0);
        set_ch(0, 32'hCCCC_0003);
        in_valid = 1'b1;
        check("t4_ready_full", 64'(in_ready), 64'd0);
        check("t4_state_two", 64'(dbg_state), 64'(ST_TWO));
        idle(3);
        check("t4_hold_data", 64'(out_data), 64'hAAAA_0001);
        check("t4_still_full", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        send(2'd0, 2'b00, 2'd0, 1'b0);
        idle(4);
        check("t4_count", 64'(got_q.size()), 64'd3);
        if (got_q.size() == 3) begin
            check("t4_first", 64'(got_q[0]), 64'hAAAA_0001);
            check("t4_second", 64'(got_q[1]), 64'hBBBB_0002);
            check("t4_third", 64'(got_q[2]), 64'hCCCC_0003);
        end

        // push and pop on the same edge in ONE
        set_ch(1, 32'h0000_00A5); send(2'd1, 2'b10, 2'd0, 1'b1);
        check("t5_state_one_a", 64'(dbg_state), 64'(ST_ONE));
        set_ch(1, 32'h0000_5A00); send(2'd1, 2'b10, 2'd1, 1'b1);
        check("t5_state_one_b", 64'(dbg_state), 64'(ST_ONE));
        check("t5_valid", 64'(out_valid), 64'd1);
        check("t5_data", 64'(out_data), 64'h0000_005A);
        idle(1);
        check("t5_drained", 64'(dbg_state), 64'(ST_EMPTY));

        // asynchronous reset while full
        out_ready = 1'b0;
        set_ch(2, 32'h1357_9BDF); send(2'd2, 2'b00, 2'd0, 1'b0);
        set_ch(2, 32'h2468_ACE0); send(2'd2, 2'b00, 2'd0, 1'b0);
        check("t6_full", 64'(dbg_state), 64'(ST_TWO));
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(out_valid), 64'd0);
        check("t6_rst_ready", 64'(in_ready), 64'd0);
        check("t6_rst_data", 64'(out_data), 64'd0);
        check("t6_rst_state", 64'(dbg_state), 64'(ST_EMPTY));
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("t6_ready_low", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        check("t6_ready_high", 64'(in_ready), 64'd1);
        check("t6_valid_low", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        set_ch(1, 32'hFEDC_BA98); send(2'd1, 2'b01, 2'd2, 1'b1);
        check("t6_after_data", 64'(out_data), 64'h0000_FEDC);
        idle(3);
        check("final_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
